// File: rtl/text_term_pkg.sv
// Shared state encoding, ASCII codes and default screen geometry for the text terminal controller.
package text_term_pkg;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_CLEAR} state_t;

  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam int         COLS_DEF         = 70;
  localparam int         ROWS_DEF         = 30;
  localparam logic [7:0] BLANK_DEF        = 8'h20;
  localparam int         BLINK_CYCLES_DEF = 25000000;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_SPACE) && (c <= ASC_TILDE);
  endfunction

endpackage

// File: rtl/text_term_if.sv
// Character input handshake (valid/ready) plus the single-byte character-memory write port.
interface text_term_if;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (output ch_valid, ch_data, input ch_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input ch_valid, ch_data, output ch_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/text_term_addr.sv
// Maps a logical (row, col) plus the scroll offset to a character-memory address; purely combinational.
// Shared with the display-side lookup so both agree on the physical row rotation.
module text_term_addr
  import text_term_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic [4:0]  i_top_row,
  input  logic [4:0]  i_row,
  input  logic [6:0]  i_col,
  output logic [11:0] o_addr
);

  logic [5:0] w_sum;
  logic [4:0] w_phys_row;

  // Both operands are below ROWS, so a single conditional subtract is the full modulo.
  assign w_sum      = {1'b0, i_top_row} + {1'b0, i_row};
  assign w_phys_row = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
  assign o_addr     = ({7'd0, w_phys_row} * 12'(COLS)) + {5'd0, i_col};

endmodule

// File: rtl/text_term_ctrl.sv
// Text terminal controller: ASCII in, one character-memory write per cycle out; 1-cycle write latency,
// ch_ready high only in IDLE (max 1 char / 2 cycles). Define TEXT_TERM_BLINK_EN for a blinking cursor.
module text_term_ctrl
  import text_term_pkg::*;
#(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
`ifdef TEXT_TERM_BLINK_EN
  , parameter int       BLINK_CYCLES = BLINK_CYCLES_DEF
`endif
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  text_term_if.slave       io_term,
  output logic [4:0]       o_top_row,
  output logic [4:0]       o_cursor_row,
  output logic [6:0]       o_cursor_col,
  output logic             o_busy,
  output logic             o_cursor_vis
);

  localparam logic [11:0] CELLS    = 12'(ROWS * COLS);
  localparam logic [6:0]  COLS_W   = 7'(COLS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  state_t      r_state, w_nxt_state;
  logic [4:0]  r_row, w_nxt_row;
  logic [4:0]  r_top, w_nxt_top;
  logic [6:0]  r_col, w_nxt_col;
  logic [6:0]  r_clr_idx, w_nxt_clr;
  logic [11:0] r_init_cnt, w_nxt_init;
  logic        r_scroll, w_nxt_scroll;
  logic        r_mem_we, w_nxt_we;
  logic [11:0] r_mem_addr, w_nxt_addr;
  logic [7:0]  r_mem_wdata, w_nxt_wdata;

  logic [6:0]  w_addr_col;
  logic [11:0] w_cell_addr;
  logic [4:0]  w_nl_row, w_nl_top;
  logic        w_nl_scroll;

  // After a scroll the cursor sits on the last logical row with top_row already advanced,
  // so the same address path lands on the recycled (old top) physical row during CLEAR.
  assign w_addr_col = (r_state != ST_IDLE)        ? r_clr_idx :
                      (io_term.ch_data == ASC_BS) ? r_col - 7'd1 : r_col;

  text_term_addr #(.COLS(COLS), .ROWS(ROWS)) u_addr (
    .i_top_row (r_top),
    .i_row     (r_row),
    .i_col     (w_addr_col),
    .o_addr    (w_cell_addr)
  );

  assign w_nl_scroll = (r_row == LAST_ROW);
  assign w_nl_row    = w_nl_scroll ? r_row : r_row + 5'd1;
  assign w_nl_top    = !w_nl_scroll ? r_top : (r_top == LAST_ROW) ? 5'd0 : r_top + 5'd1;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_row    = r_row;
    w_nxt_top    = r_top;
    w_nxt_col    = r_col;
    w_nxt_clr    = r_clr_idx;
    w_nxt_init   = r_init_cnt;
    w_nxt_scroll = r_scroll;
    w_nxt_we     = 1'b0;
    w_nxt_addr   = r_mem_addr;
    w_nxt_wdata  = r_mem_wdata;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == CELLS) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_we    = 1'b1;
          w_nxt_addr  = r_init_cnt;
          w_nxt_wdata = BLANK;
          w_nxt_init  = r_init_cnt + 12'd1;
        end
      end
      ST_IDLE: begin
        if (io_term.ch_valid) begin
          w_nxt_clr = 7'd0;
          if (is_printable(io_term.ch_data)) begin
            w_nxt_state = ST_WRITE;
            w_nxt_we    = 1'b1;
            w_nxt_addr  = w_cell_addr;
            w_nxt_wdata = io_term.ch_data;
            if (r_col == LAST_COL) begin
              w_nxt_col    = 7'd0;
              w_nxt_row    = w_nl_row;
              w_nxt_top    = w_nl_top;
              w_nxt_scroll = w_nl_scroll;
            end else begin
              w_nxt_col = r_col + 7'd1;
            end
          end else if ((io_term.ch_data == ASC_LF) || (io_term.ch_data == ASC_CR)) begin
            w_nxt_state  = ST_WRITE;
            w_nxt_col    = 7'd0;
            w_nxt_row    = w_nl_row;
            w_nxt_top    = w_nl_top;
            w_nxt_scroll = w_nl_scroll;
          end else if ((io_term.ch_data == ASC_BS) && (r_col != 7'd0)) begin
            w_nxt_state = ST_WRITE;
            w_nxt_col   = r_col - 7'd1;
            w_nxt_we    = 1'b1;
            w_nxt_addr  = w_cell_addr;
            w_nxt_wdata = BLANK;
          end
        end
      end
      ST_WRITE: begin
        if (r_scroll) begin
          w_nxt_state  = ST_CLEAR;
          w_nxt_we     = 1'b1;
          w_nxt_addr   = w_cell_addr;
          w_nxt_wdata  = BLANK;
          w_nxt_clr    = r_clr_idx + 7'd1;
          w_nxt_scroll = 1'b0;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (r_clr_idx == COLS_W) begin
          w_nxt_state = ST_IDLE;
        end else begin
          w_nxt_we    = 1'b1;
          w_nxt_addr  = w_cell_addr;
          w_nxt_wdata = BLANK;
          w_nxt_clr   = r_clr_idx + 7'd1;
        end
      end
      default: w_nxt_state = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state     <= ST_INIT;
      r_row       <= 5'd0;
      r_top       <= 5'd0;
      r_col       <= 7'd0;
      r_clr_idx   <= 7'd0;
      r_init_cnt  <= 12'd0;
      r_scroll    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 12'd0;
      r_mem_wdata <= BLANK;
    end else begin
      r_state     <= w_nxt_state;
      r_row       <= w_nxt_row;
      r_top       <= w_nxt_top;
      r_col       <= w_nxt_col;
      r_clr_idx   <= w_nxt_clr;
      r_init_cnt  <= w_nxt_init;
      r_scroll    <= w_nxt_scroll;
      r_mem_we    <= w_nxt_we;
      r_mem_addr  <= w_nxt_addr;
      r_mem_wdata <= w_nxt_wdata;
    end
  end

  assign io_term.ch_ready  = (r_state == ST_IDLE);
  assign io_term.mem_we    = r_mem_we;
  assign io_term.mem_addr  = r_mem_addr;
  assign io_term.mem_wdata = r_mem_wdata;
  assign o_top_row         = r_top;
  assign o_cursor_row      = r_row;
  assign o_cursor_col      = r_col;
  assign o_busy            = (r_state == ST_INIT) || (r_state == ST_CLEAR);

`ifdef TEXT_TERM_BLINK_EN
  logic [31:0] r_blink_cnt;
  logic        r_vis;
  logic        w_accept;

  assign w_accept = (r_state == ST_IDLE) && io_term.ch_valid;

  // Any accepted keystroke restarts the blink phase so the cursor stays solid while typing.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_blink_cnt <= 32'd0;
      r_vis       <= 1'b1;
    end else if (w_accept) begin
      r_blink_cnt <= 32'd0;
      r_vis       <= 1'b1;
    end else if (r_blink_cnt == 32'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= 32'd0;
      r_vis       <= ~r_vis;
    end else begin
      r_blink_cnt <= r_blink_cnt + 32'd1;
    end
  end

  assign o_cursor_vis = r_vis;
`else
  assign o_cursor_vis = 1'b1;
`endif

endmodule

// File: tb/tb_text_term_ctrl.sv
// Bench for text_term_ctrl: expected memory writes are queued by the stimulus and popped by a write monitor.
module tb_text_term_ctrl;
  import text_term_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] top_row, cur_row;
  logic [6:0] cur_col;
  logic       busy, cur_vis;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  text_term_if io_t();

  text_term_ctrl dut (
    .i_clk        (clk),
    .i_resetn     (resetn),
    .io_term      (io_t),
    .o_top_row    (top_row),
    .o_cursor_row (cur_row),
    .o_cursor_col (cur_col),
    .o_busy       (busy),
    .o_cursor_vis (cur_vis)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input int d);
    exp_q.push_back({12'(a), 8'(d)});
  endtask

  task automatic push_blank_row(input int base);
    for (int i = 0; i < 70; i++) push(base + i, 8'h20);
  endtask

  task automatic send(input logic [7:0] c);
    int n = 0;
    @(posedge clk); #1;
    while (io_t.ch_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", int'(io_t.ch_ready), 1);
    io_t.ch_valid = 1'b1;
    io_t.ch_data  = c;
    @(posedge clk); #1;
    io_t.ch_valid = 1'b0;
  endtask

  task automatic wait_init();
    int  first = -1;
    int  cyc = 0;
    bit  done = 0;
    while (!done && cyc < 2500) begin
      @(negedge clk);
      if (first < 0 && io_t.mem_we === 1'b1) begin
        first = cyc;
        check("init_busy", int'(busy), 1);
      end
      if (io_t.ch_ready === 1'b1) done = 1;
      else cyc++;
    end
    check("init_ready_delay", done ? cyc - first : -1, 2100);
    check("init_busy_done", int'(busy), 0);
    check("init_queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, int'(io_t.mem_we), 0);
    check({tag, "_addr"}, int'(io_t.mem_addr), 0);
    check({tag, "_wdata"}, int'(io_t.mem_wdata), 32);
    check({tag, "_ready"}, int'(io_t.ch_ready), 0);
    check({tag, "_busy"}, int'(busy), 1);
    check({tag, "_vis"}, int'(cur_vis), 1);
    check({tag, "_top"}, int'(top_row), 0);
    check({tag, "_row"}, int'(cur_row), 0);
    check({tag, "_col"}, int'(cur_col), 0);
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && io_t.mem_we === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr %0d data %h, queue empty", io_t.mem_addr, io_t.mem_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if ({io_t.mem_addr, io_t.mem_wdata} !== mon_e) begin
            n_err++;
            $display("FAIL mem_write: got addr %0d data %h, want addr %0d data %h",
                     io_t.mem_addr, io_t.mem_wdata, mon_e[19:8], mon_e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    io_t.ch_valid = 1'b0;
    io_t.ch_data  = 8'h00;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    for (int i = 0; i < 2100; i++) push(i, 8'h20);
    resetn = 1'b1;
    wait_init();
    check("post_init_top", int'(top_row), 0);
    check("post_init_col", int'(cur_col), 0);

    // First printable: write one cycle later, ready low for exactly one cycle
    push(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    check("a_we", int'(io_t.mem_we), 1);
    check("a_ready_low", int'(io_t.ch_ready), 0);
    check("a_col", int'(cur_col), 1);
    @(negedge clk);
    check("a_ready_back", int'(io_t.ch_ready), 1);
    check("a_we_off", int'(io_t.mem_we), 0);

    push(1, 8'h42); send(8'h42);
    push(2, 8'h43); send(8'h43);
    push(2, 8'h20); send(ASC_BS);
    @(negedge clk);
    check("bs_col", int'(cur_col), 2);
    push(1, 8'h20); send(ASC_BS);
    push(0, 8'h20); send(ASC_BS);
    send(ASC_BS);
    @(negedge clk);
    check("bs0_no_write", int'(io_t.mem_we), 0);
    check("bs0_col", int'(cur_col), 0);
    check("bs0_row", int'(cur_row), 0);
    send(8'h07);
    @(negedge clk);
    check("other_ready", int'(io_t.ch_ready), 1);
    check("other_col", int'(cur_col), 0);

    // Full row of printables wraps to row 1 without scrolling
    for (int i = 0; i < 70; i++) begin
      push(i, 8'h61 + 8'(i % 26));
      send(8'h61 + 8'(i % 26));
    end
    @(negedge clk);
    check("wrap_row", int'(cur_row), 1);
    check("wrap_col", int'(cur_col), 0);
    check("wrap_top", int'(top_row), 0);
    @(negedge clk);
    check("wrap_no_clear", int'(busy), 0);

    push(70, 8'h58); send(8'h58);
    send(ASC_CR);
    @(negedge clk);
    check("cr_row", int'(cur_row), 2);
    check("cr_col", int'(cur_col), 0);
    for (int i = 0; i < 27; i++) send(ASC_LF);
    @(negedge clk);
    check("lf_row29", int'(cur_row), 29);
    push(2030, 8'h59); send(8'h59);

    // Newline on the last row: scroll and clear the old top row
    push_blank_row(0);
    send(ASC_LF);
    @(negedge clk);
    check("scroll_top", int'(top_row), 1);
    check("scroll_row", int'(cur_row), 29);
    check("scroll_col", int'(cur_col), 0);
    @(negedge clk);
    check("scroll_busy", int'(busy), 1);
    push(0, 8'h42); send(8'h42);
    @(negedge clk);
    check("b_col", int'(cur_col), 1);

    for (int k = 1; k <= 28; k++) begin
      push_blank_row(k * 70);
      send(ASC_LF);
    end
    @(negedge clk);
    check("top29", int'(top_row), 29);
    push_blank_row(2030);
    send(ASC_LF);
    @(negedge clk);
    check("top_wrap0", int'(top_row), 0);
    push(2030, 8'h5A); send(8'h5A);

    // Printable in the last column of the last row also scrolls
    for (int i = 0; i < 69; i++) begin
      push(2031 + i, 8'h61 + 8'(i % 26));
      if (i == 68) push_blank_row(0);
      send(8'h61 + 8'(i % 26));
    end
    @(negedge clk);
    check("wscroll_top", int'(top_row), 1);
    check("wscroll_row", int'(cur_row), 29);
    check("wscroll_col", int'(cur_col), 0);

    // Reset in the middle of a clear (index 35)
    push_blank_row(70);
    send(ASC_LF);
    repeat (36) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_clear_progress", exp_q.size(), 35);
    exp_q.delete();
    for (int i = 0; i < 2100; i++) push(i, 8'h20);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    wait_init();
    check("reinit_top", int'(top_row), 0);
    check("reinit_row", int'(cur_row), 0);
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
